framebuffer_ctrl: RTL and testbench

Monochrome 640x480 frame buffer that sits directly upstream of the HDMI display stage. It stores one bit per pixel, packed as 32-bit words, 20 words per line. Its read port answers the display's word address with the pixel word. Its command port lets the CPU or graphics logic set, clear or toggle single pixels and fill the whole screen, using read-modify-write sequencing.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/framebuffer_ctrl_if.sv | 24 ++
 rtl/fb_ram.sv | 28 ++
 rtl/framebuffer_ctrl.sv | 158 +++++++++++++++
 tb/tb_framebuffer_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants, op codes and FSM state type for the monochrome 640x480 frame buffer.
package fb_pkg;

  localparam int FB_W           = 640;
  localparam int FB_H           = 480;
  localparam int WORDS_PER_LINE = FB_W / 32;
  localparam int FB_WORDS       = FB_H * WORDS_PER_LINE;
  localparam int ADDR_W         = 14;

  typedef logic [1:0] fb_op_t;

  localparam fb_op_t OP_SET    = 2'b00;
  localparam fb_op_t OP_CLR    = 2'b01;
  localparam fb_op_t OP_TOGGLE = 2'b10;
  localparam fb_op_t OP_FILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
`ifdef FB_FILL_EN
    , ST_FILL
`endif
  } fb_state_e;

endpackage

// File: rtl/framebuffer_ctrl_if.sv
// Pixel command handshake plus status pulses between a command source and framebuffer_ctrl.
interface framebuffer_ctrl_if;
  import fb_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  fb_op_t     cmd_op;
  logic [9:0] cmd_x;
  logic [8:0] cmd_y;
  logic       cmd_fill;
  logic       busy;
  logic       done;
  logic       err_oob;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_fill,
    input  cmd_ready, busy, done, err_oob
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_fill,
    output cmd_ready, busy, done, err_oob
  );
endinterface

// File: rtl/fb_ram.sv
// True dual-port read-first block RAM: port A read-only (display), port B read/write (commands).
module fb_ram
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [31:0]       a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [31:0]       b_d,
  output logic [31:0]       b_q
);

  logic [31:0] mem [0:FB_WORDS-1];

  always_ff @(posedge clk) begin
    a_q <= mem[a_addr];
  end

  // Non-blocking update keeps both ports read-first on a same-address collision.
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_d;
    end
    b_q <= mem[b_addr];
  end

endmodule

// File: rtl/framebuffer_ctrl.sv
// 640x480 1bpp frame buffer: display read port plus read-modify-write pixel command port.
// Whole-screen FILL is built only when FB_FILL_EN is defined; otherwise op 11 completes as a no-op.
module framebuffer_ctrl
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         disp_addr,
  output logic [31:0]         disp_data,
  framebuffer_ctrl_if.slave   cmd
);

  fb_state_e         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       mask_reg;
  fb_op_t            op_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              disp_zero_reg;
`ifdef FB_FILL_EN
  logic              fill_val_reg;
`endif

  logic [31:0]       ram_a_q;
  logic [31:0]       ram_b_q;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic              handshake;
  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;
  logic [31:0]       pix_mask;

  assign cmd.cmd_ready = ready_reg & ~rst;
  assign cmd.busy      = busy_reg;
  assign cmd.done      = done_reg;
  assign cmd.err_oob   = err_reg;

  assign handshake = cmd.cmd_valid & cmd.cmd_ready;
  assign in_range  = (cmd.cmd_x < 10'(FB_W)) && (cmd.cmd_y < 9'(FB_H));
  // y*20 as (y<<4)+(y<<2); leftmost pixel of a word sits in the MSB.
  assign pix_addr  = ({5'd0, cmd.cmd_y} << 4) + ({5'd0, cmd.cmd_y} << 2) + {9'd0, cmd.cmd_x[9:5]};
  assign pix_mask  = 32'h8000_0000 >> cmd.cmd_x[4:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_data = ram_b_q;
    case (op_reg)
      OP_SET:    wr_data = ram_b_q | mask_reg;
      OP_CLR:    wr_data = ram_b_q & ~mask_reg;
      OP_TOGGLE: wr_data = ram_b_q ^ mask_reg;
      default:   wr_data = ram_b_q;
    endcase
    if (state_reg == ST_WR) begin
      wr_en = ~rst;
    end
`ifdef FB_FILL_EN
    if (state_reg == ST_FILL) begin
      wr_en   = ~rst;
      wr_data = {32{fill_val_reg}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      mask_reg  <= '0;
      op_reg    <= OP_SET;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef FB_FILL_EN
      fill_val_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (handshake) begin
            if (cmd.cmd_op == OP_FILL) begin
`ifdef FB_FILL_EN
              addr_reg     <= '0;
              fill_val_reg <= cmd.cmd_fill;
              state_reg    <= ST_FILL;
              ready_reg    <= 1'b0;
              busy_reg     <= 1'b1;
`else
              done_reg     <= 1'b1;
`endif
            end else if (!in_range) begin
              err_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              addr_reg  <= pix_addr;
              mask_reg  <= pix_mask;
              op_reg    <= cmd.cmd_op;
              state_reg <= ST_RD;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state_reg <= ST_WR;
          done_reg  <= 1'b1;
        end
        ST_WR: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
`ifdef FB_FILL_EN
        // addr_reg doubles as the fill word counter; done lines up with the last write.
        ST_FILL: begin
          if (addr_reg == ADDR_W'(FB_WORDS - 2)) begin
            done_reg <= 1'b1;
          end
          if (addr_reg == ADDR_W'(FB_WORDS - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else begin
            addr_reg <= addr_reg + 1'b1;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range display addresses read as blank; decided at address time, applied at data time.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_zero_reg <= 1'b1;
    end else begin
      disp_zero_reg <= (disp_addr >= 32'(FB_WORDS));
    end
  end

  assign disp_data = disp_zero_reg ? 32'h0 : ram_a_q;

  fb_ram u_ram (
    .clk    (clk),
    .a_addr (disp_addr[ADDR_W-1:0]),
    .a_q    (ram_a_q),
    .b_addr (addr_reg),
    .b_we   (wr_en),
    .b_d    (wr_data),
    .b_q    (ram_b_q)
  );

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Self-checking bench for framebuffer_ctrl: directed boundary cases plus random pixel ops against a word-array model.
module tb_framebuffer_ctrl;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] disp_addr;
  logic [31:0] disp_data;

  framebuffer_ctrl_if cmd_bus ();

  framebuffer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .cmd       (cmd_bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [0:FB_WORDS-1];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp_check(input logic [31:0] addr, input string tag);
    logic [31:0] exp;
    disp_addr = addr;
    tick();
    exp = (addr < FB_WORDS) ? model_mem[addr[13:0]] : 32'h0;
    check_val(tag, disp_data, exp);
    $display("disp read addr=%0d data=0x%08h", addr, disp_data);
  endtask

  function automatic void model_apply(input logic [1:0] op, input int x, input int y);
    int a;
    logic [31:0] m;
    a = y * WORDS_PER_LINE + x / 32;
    m = 32'h8000_0000 >> (x % 32);
    if (op == OP_SET)    model_mem[a] = model_mem[a] | m;
    if (op == OP_CLR)    model_mem[a] = model_mem[a] & ~m;
    if (op == OP_TOGGLE) model_mem[a] = model_mem[a] ^ m;
  endfunction

  task automatic pixel_op(input logic [1:0] op, input int x, input int y, input string tag);
    int a;
    int al;
    logic [31:0] old_w;
    bit ok;
    ok = (x < FB_W) && (y < FB_H);
    check_val({tag, "_ready_T"}, cmd_bus.cmd_ready, 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_x     = 10'(x);
    cmd_bus.cmd_y     = 9'(y);
    cmd_bus.cmd_fill  = 1'($urandom);
    tick();
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'($urandom);
    cmd_bus.cmd_x     = 10'($urandom);
    cmd_bus.cmd_y     = 9'($urandom);
    if (ok) begin
      a = y * WORDS_PER_LINE + x / 32;
      old_w = model_mem[a];
      check_val({tag, "_busy_T1"}, cmd_bus.busy, 1);
      check_val({tag, "_ready_T1"}, cmd_bus.cmd_ready, 0);
      check_val({tag, "_done_T1"}, cmd_bus.done, 0);
      tick();
      check_val({tag, "_done_T2"}, cmd_bus.done, 1);
      check_val({tag, "_busy_T2"}, cmd_bus.busy, 1);
      disp_addr = a;
      tick();
      check_val({tag, "_readfirst"}, disp_data, old_w);
      check_val({tag, "_ready_T3"}, cmd_bus.cmd_ready, 1);
      check_val({tag, "_done_T3"}, cmd_bus.done, 0);
      check_val({tag, "_busy_T3"}, cmd_bus.busy, 0);
      model_apply(op, x, y);
      tick();
      check_val({tag, "_newword"}, disp_data, model_mem[a]);
      $display("pixel op=%0d x=%0d y=%0d word=%0d old=0x%08h new=0x%08h", op, x, y, a, old_w, disp_data);
    end else begin
      check_val({tag, "_err_T1"}, cmd_bus.err_oob, 1);
      check_val({tag, "_done_T1"}, cmd_bus.done, 1);
      check_val({tag, "_busy_T1"}, cmd_bus.busy, 0);
      check_val({tag, "_ready_T1"}, cmd_bus.cmd_ready, 1);
      tick();
      check_val({tag, "_err_T2"}, cmd_bus.err_oob, 0);
      check_val({tag, "_done_T2"}, cmd_bus.done, 0);
      $display("pixel op=%0d x=%0d y=%0d dropped out of range", op, x, y);
      al = (y * WORDS_PER_LINE + x / 32) % 16384;
      if (al < FB_WORDS) disp_check(al, {tag, "_alias_unchanged"});
    end
  endtask

`ifdef FB_FILL_EN
  task automatic fill_op(input logic v, input string tag);
    int done_cnt;
    int done_at;
    int busy_cnt;
    int ready_hi;
    done_cnt = 0; done_at = -1; busy_cnt = 0; ready_hi = 0;
    check_val({tag, "_ready_T"}, cmd_bus.cmd_ready, 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_FILL;
    cmd_bus.cmd_fill  = v;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_fill  = ~v;
    for (int k = 1; k <= FB_WORDS; k++) begin
      if (cmd_bus.busy) busy_cnt++;
      if (cmd_bus.cmd_ready) ready_hi++;
      if (cmd_bus.done) begin
        done_cnt++;
        done_at = k;
      end
      tick();
    end
    check_val({tag, "_busy_cycles"}, busy_cnt, FB_WORDS);
    check_val({tag, "_ready_during"}, ready_hi, 0);
    check_val({tag, "_done_count"}, done_cnt, 1);
    check_val({tag, "_done_at"}, done_at, FB_WORDS);
    check_val({tag, "_busy_after"}, cmd_bus.busy, 0);
    check_val({tag, "_ready_after"}, cmd_bus.cmd_ready, 1);
    $display("fill value=%0d busy_cycles=%0d done_at=T+%0d", v, busy_cnt, done_at);
    for (int i = 0; i < FB_WORDS; i++) model_mem[i] = {32{v}};
    disp_check(0, {tag, "_word0"});
    disp_check(FB_WORDS - 1, {tag, "_wordlast"});
    disp_check($urandom_range(0, FB_WORDS - 1), {tag, "_wordrnd"});
  endtask
`else
  task automatic fill_nop(input string tag);
    check_val({tag, "_ready_T"}, cmd_bus.cmd_ready, 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_FILL;
    cmd_bus.cmd_fill  = 1'b1;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    check_val({tag, "_done_T1"}, cmd_bus.done, 1);
    check_val({tag, "_busy_T1"}, cmd_bus.busy, 0);
    check_val({tag, "_ready_T1"}, cmd_bus.cmd_ready, 1);
    check_val({tag, "_err_T1"}, cmd_bus.err_oob, 0);
    tick();
    check_val({tag, "_done_T2"}, cmd_bus.done, 0);
    $display("fill op accepted as no-op");
    disp_check(0, {tag, "_word0"});
    disp_check(FB_WORDS - 1, {tag, "_wordlast"});
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < FB_WORDS; i++) model_mem[i] = 32'h0;
    rst = 1'b1;
    disp_addr = 32'd0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_SET;
    cmd_bus.cmd_x     = '0;
    cmd_bus.cmd_y     = '0;
    cmd_bus.cmd_fill  = 1'b0;
    tick(); tick(); tick();
    check_val("rst_ready", cmd_bus.cmd_ready, 0);
    check_val("rst_busy", cmd_bus.busy, 0);
    check_val("rst_done", cmd_bus.done, 0);
    check_val("rst_err", cmd_bus.err_oob, 0);
    check_val("rst_disp", disp_data, 0);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", cmd_bus.cmd_ready, 1);
    $display("reset released");

    pixel_op(OP_SET, 33, 2, "set_33_2");
    pixel_op(OP_SET, 639, 479, "set_corner");
    pixel_op(OP_TOGGLE, 639, 479, "tgl_corner");
    pixel_op(OP_CLR, 0, 0, "clr_clear");
    pixel_op(OP_SET, 0, 0, "set_origin");
    pixel_op(OP_SET, 640, 2, "oob_x");
    pixel_op(OP_SET, 5, 480, "oob_y");
    pixel_op(OP_TOGGLE, 1023, 511, "oob_xy");
    disp_check(41, "word41");
    disp_check(FB_WORDS, "disp_oob_9600");
    disp_check(32'hFFFF_FFFF, "disp_oob_max");
    disp_check(32'd16384 + 32'd41, "disp_oob_alias");

`ifdef FB_FILL_EN
    fill_op(1'b1, "fill1");
    fill_op(1'b0, "fill0");
`else
    fill_nop("fill_nop");
`endif

    for (int i = 0; i < 80; i++) begin
      int r;
      int x;
      int y;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        x = $urandom_range(FB_W, 1023);
        y = $urandom_range(0, 511);
      end else if (r == 1) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(FB_H, 511);
      end else if (r < 6) begin
        x = $urandom_range(0, FB_W - 1);
        y = $urandom_range(0, 3);
      end else begin
        x = $urandom_range(0, FB_W - 1);
        y = $urandom_range(0, FB_H - 1);
      end
      pixel_op(2'($urandom_range(0, 2)), x, y, "rnd");
      if (i % 8 == 0) disp_check($urandom_range(0, FB_WORDS + 200), "rnd_disp");
    end

`ifdef FB_FILL_EN
    check_val("abort_ready_T", cmd_bus.cmd_ready, 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = OP_FILL;
    cmd_bus.cmd_fill  = 1'b1;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    for (int k = 1; k < 100; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("abort_busy", cmd_bus.busy, 0);
    check_val("abort_ready", cmd_bus.cmd_ready, 1);
    $display("fill aborted by reset at T+100");
    for (int i = 0; i < 99; i++) model_mem[i] = 32'hFFFF_FFFF;
    pixel_op(OP_SET, 7, 400, "after_abort");
    disp_check(50, "abort_word50");
    disp_check(98, "abort_word98");
    disp_check(200, "abort_word200");
    disp_check(FB_WORDS - 1, "abort_wordlast");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
